// File: rtl/router_pkt_tx_pkg.sv
// ---------------------------------------------------------------------------
// router_pkt_tx_pkg
// Shared definitions for the router packet source:
//   - transmitter FSM state encoding
//   - header field positions (length [7:2], address [1:0])
//   - the reserved destination address that the router cannot route
//   - header build and parity accumulation helpers
// ---------------------------------------------------------------------------
package router_pkt_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PLD  = 3'd2,
        ST_PAR  = 3'd3,
        ST_CHK  = 3'd4
    } tx_state_e;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    // The router has three output ports; address 3 has no destination.
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    function automatic logic [7:0] make_header(input logic [5:0] len,
                                               input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = 8'd0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

    // Packet parity is the bytewise XOR of header and all payload bytes.
    function automatic logic [7:0] parity_update(input logic [7:0] acc,
                                                 input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// ---------------------------------------------------------------------------
// router_pkt_tx_if
// Byte-stream link between the packet source and the router input port.
//   data_out  : byte presented to router data_in
//   pkt_valid : packet-valid to the router (high for header and payload)
//   busy      : router back-pressure; a byte moves only on an edge with busy=0
//   err       : router parity-error verdict
// master = packet source, slave = router.
// ---------------------------------------------------------------------------
interface router_pkt_tx_if;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       busy;
    logic       err;

    modport master (output data_out, output pkt_valid, input busy, input err);
    modport slave  (input data_out, input pkt_valid, output busy, output err);
endinterface

// File: rtl/router_tx_buf.sv
// ---------------------------------------------------------------------------
// router_tx_buf
// Payload buffer, MAX_LEN bytes deep, filled strictly in order.
//   clock, resetn : clock and asynchronous active-low reset (count only)
//   wr_en, wr_data: append one byte; ignored when full
//   clr           : empty the buffer (wins over wr_en)
//   rd_idx        : read index, rd_data is an asynchronous read
//   count, full   : registered fill level and full flag
// ---------------------------------------------------------------------------
module router_tx_buf #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic       clr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_idx,
    output logic [7:0] rd_data,
    output logic [5:0] count,
    output logic       full
);

    localparam logic [5:0] DEPTH = 6'(MAX_LEN);

    logic [7:0] mem_r [MAX_LEN];
    logic [5:0] count_r;
    logic       full_r;
    logic       wr_ok_s;

    // Qualify writes: clr takes precedence, and a full buffer drops bytes.
    always_comb begin
        wr_ok_s = 1'b0;
        if (wr_en && !clr && (count_r < DEPTH)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Fill level and full flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= 6'd0;
            full_r  <= 1'b0;
        end else if (clr) begin
            count_r <= 6'd0;
            full_r  <= 1'b0;
        end else if (wr_ok_s) begin
            count_r <= count_r + 6'd1;
            full_r  <= ((count_r + 6'd1) == DEPTH);
        end else begin
            count_r <= count_r;
            full_r  <= full_r;
        end
    end

    // Payload storage; contents are meaningless beyond count, so no reset.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_r[count_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];
    assign count   = count_r;
    assign full    = full_r;

endmodule

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
// Packet source for the 1x3 router input port. Buffers payload bytes, then
// on start frames header / payload / parity to the router honouring busy,
// and finally samples the router err output for ERR_WAIT cycles.
//   clock, resetn         : clock, asynchronous active-low reset
//   wr_en, wr_data, clr   : payload buffer load / clear (IDLE only)
//   start, dest_addr      : begin transmission to port 0..2
//   rtr (master)          : data_out, pkt_valid, busy, err link to router
//   tx_active             : not in IDLE
//   buf_count, buf_full   : buffer fill level
//   done                  : one-cycle pulse at end of error sampling
//   parity_err            : err seen during sampling, held to next start
//   reject                : one-cycle pulse for a refused start
// All outputs are registered; busy only reaches data_out through a flop.
// ---------------------------------------------------------------------------
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   clr,
    input  logic                   start,
    input  logic [1:0]             dest_addr,
    router_pkt_tx_if.master        rtr,
    output logic                   tx_active,
    output logic [5:0]             buf_count,
    output logic                   buf_full,
    output logic                   done,
    output logic                   parity_err,
    output logic                   reject
);

    localparam int CNT_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ERR_WAIT - 1);

    tx_state_e        state_r, state_s;
    logic [5:0]       len_r, len_s;
    logic [1:0]       addr_r, addr_s;
    logic [5:0]       idx_r, idx_s;
    logic [7:0]       parity_r, parity_s;
    logic [CNT_W-1:0] chk_cnt_r, chk_cnt_s;
    logic             err_flag_r, err_flag_s;
    logic [7:0]       data_out_r, data_out_s;
    logic             pkt_valid_r, pkt_valid_s;
    logic             tx_active_r, tx_active_s;
    logic             done_r, done_s;
    logic             parity_err_r, parity_err_s;
    logic             reject_r, reject_s;

    logic             buf_wr_s;
    logic             buf_clr_s;
    logic [5:0]       rd_idx_s;
    logic [7:0]       rd_data_s;
    logic [5:0]       count_s;
    logic             full_s;

    router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (buf_wr_s),
        .clr     (buf_clr_s),
        .wr_data (wr_data),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s),
        .count   (count_s),
        .full    (full_s)
    );

    // Look-ahead read index: the byte to present after the current transfer.
    always_comb begin
        rd_idx_s = 6'd0;
        if (state_r == ST_PLD) begin
            rd_idx_s = idx_r + 6'd1;
        end else begin
            rd_idx_s = 6'd0;
        end
    end

    // Next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        addr_s       = addr_r;
        idx_s        = idx_r;
        parity_s     = parity_r;
        chk_cnt_s    = chk_cnt_r;
        err_flag_s   = err_flag_r;
        data_out_s   = data_out_r;
        pkt_valid_s  = pkt_valid_r;
        done_s       = 1'b0;
        parity_err_s = parity_err_r;
        reject_s     = 1'b0;
        buf_wr_s     = 1'b0;
        buf_clr_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                data_out_s  = 8'd0;
                pkt_valid_s = 1'b0;
                if (clr) begin
                    buf_clr_s = 1'b1;
                end else if (start) begin
                    if ((count_s == 6'd0) || (dest_addr == ADDR_INVALID)) begin
                        reject_s = 1'b1;
                    end else begin
                        len_s        = count_s;
                        addr_s       = dest_addr;
                        parity_err_s = 1'b0;
                        data_out_s   = make_header(count_s, dest_addr);
                        pkt_valid_s  = 1'b1;
                        state_s      = ST_HDR;
                    end
                end else if (wr_en) begin
                    // The buffer itself drops the byte when full.
                    buf_wr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HDR: begin
                if (!rtr.busy) begin
                    parity_s    = data_out_r;
                    idx_s       = 6'd0;
                    data_out_s  = rd_data_s;
                    pkt_valid_s = 1'b1;
                    state_s     = ST_PLD;
                end else begin
                    state_s = ST_HDR;
                end
            end

            ST_PLD: begin
                if (!rtr.busy) begin
                    parity_s = parity_update(parity_r, data_out_r);
                    if (idx_r == (len_r - 6'd1)) begin
                        // Present the completed parity straight away.
                        data_out_s  = parity_update(parity_r, data_out_r);
                        pkt_valid_s = 1'b0;
                        state_s     = ST_PAR;
                    end else begin
                        idx_s       = idx_r + 6'd1;
                        data_out_s  = rd_data_s;
                        pkt_valid_s = 1'b1;
                    end
                end else begin
                    state_s = ST_PLD;
                end
            end

            ST_PAR: begin
                if (!rtr.busy) begin
                    data_out_s  = 8'd0;
                    pkt_valid_s = 1'b0;
                    chk_cnt_s   = '0;
                    err_flag_s  = 1'b0;
                    state_s     = ST_CHK;
                end else begin
                    state_s = ST_PAR;
                end
            end

            ST_CHK: begin
                err_flag_s = err_flag_r | rtr.err;
                if (chk_cnt_r == CNT_LAST) begin
                    done_s       = 1'b1;
                    parity_err_s = err_flag_r | rtr.err;
                    buf_clr_s    = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    chk_cnt_s = chk_cnt_r + 1'b1;
                end
            end

            default: begin
                data_out_s  = 8'd0;
                pkt_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase

        tx_active_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            len_r        <= 6'd0;
            addr_r       <= 2'd0;
            idx_r        <= 6'd0;
            parity_r     <= 8'd0;
            chk_cnt_r    <= '0;
            err_flag_r   <= 1'b0;
            data_out_r   <= 8'd0;
            pkt_valid_r  <= 1'b0;
            tx_active_r  <= 1'b0;
            done_r       <= 1'b0;
            parity_err_r <= 1'b0;
            reject_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            addr_r       <= addr_s;
            idx_r        <= idx_s;
            parity_r     <= parity_s;
            chk_cnt_r    <= chk_cnt_s;
            err_flag_r   <= err_flag_s;
            data_out_r   <= data_out_s;
            pkt_valid_r  <= pkt_valid_s;
            tx_active_r  <= tx_active_s;
            done_r       <= done_s;
            parity_err_r <= parity_err_s;
            reject_r     <= reject_s;
        end
    end

    assign rtr.data_out  = data_out_r;
    assign rtr.pkt_valid = pkt_valid_r;
    assign tx_active     = tx_active_r;
    assign buf_count     = count_s;
    assign buf_full      = full_s;
    assign done          = done_r;
    assign parity_err    = parity_err_r;
    assign reject        = reject_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_tx
// Directed scoreboard bench for router_pkt_tx. Stimulus pushes the expected
// transferred bytes ({pkt_valid, data}), done events (cycle, parity_err) and
// reject events (cycle) into queues; a monitor pops and compares them when
// the DUT presents a transfer, done or reject.
// ---------------------------------------------------------------------------
module tb_router_pkt_tx;

    localparam int MAX_LEN  = 63;
    localparam int ERR_WAIT = 4;

    logic       clock     = 1'b0;
    logic       resetn    = 1'b0;
    logic       wr_en     = 1'b0;
    logic [7:0] wr_data   = 8'd0;
    logic       clr       = 1'b0;
    logic       start     = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic       busy      = 1'b0;
    logic       err       = 1'b0;

    logic       tx_active;
    logic [5:0] buf_count;
    logic       buf_full;
    logic       done;
    logic       parity_err;
    logic       reject;

    router_pkt_tx_if rif ();
    assign rif.busy = busy;
    assign rif.err  = err;

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr        (clr),
        .start      (start),
        .dest_addr  (dest_addr),
        .rtr        (rif.master),
        .tx_active  (tx_active),
        .buf_count  (buf_count),
        .buf_full   (buf_full),
        .done       (done),
        .parity_err (parity_err),
        .reject     (reject)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q_byte[$];
    int         q_done_cyc[$];
    logic       q_done_perr[$];
    int         q_rej[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: samples 2ns after each falling edge, well away from both edges.
    initial begin : monitor
        bit         prev_v;
        bit         par_pend;
        logic [8:0] e;
        prev_v   = 1'b0;
        par_pend = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (!resetn) begin
                prev_v   = 1'b0;
                par_pend = 1'b0;
            end else begin
                // pkt_valid falling while still active marks the parity byte.
                if (tx_active && !rif.pkt_valid && prev_v) par_pend = 1'b1;
                if (tx_active && !busy && (rif.pkt_valid || par_pend)) begin
                    if (q_byte.size() == 0) begin
                        fail_event("tx_byte");
                    end else begin
                        e = q_byte.pop_front();
                        check("tx_byte", 32'({rif.pkt_valid, rif.data_out}), 32'(e));
                    end
                    if (!rif.pkt_valid) par_pend = 1'b0;
                end
                if (done) begin
                    if (q_done_cyc.size() == 0) begin
                        fail_event("done");
                    end else begin
                        check("done_cycle", 32'(cyc), 32'(q_done_cyc.pop_front()));
                        check("done_parity_err", 32'(parity_err), 32'(q_done_perr.pop_front()));
                        check("done_buf_count", 32'(buf_count), 32'd0);
                    end
                end
                if (reject) begin
                    if (q_rej.size() == 0) begin
                        fail_event("reject");
                    end else begin
                        check("reject_cycle", 32'(cyc), 32'(q_rej.pop_front()));
                    end
                end
                prev_v = rif.pkt_valid;
            end
        end
    end

    task automatic load_byte(input logic [7:0] b);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clock);
        #1 wr_en = 1'b0;
    endtask

    task automatic push_byte(input logic v, input logic [7:0] d);
        q_byte.push_back({v, d});
    endtask

    // Pulse start; done_off < 0 means no done expected.
    task automatic fire_start(input logic [1:0] a, input bit rej, input int done_off, input logic perr);
        @(negedge clock);
        if (rej) q_rej.push_back(cyc + 1);
        if (done_off >= 0) begin
            q_done_cyc.push_back(cyc + 1 + done_off);
            q_done_perr.push_back(perr);
        end
        start     = 1'b1;
        dest_addr = a;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (q_byte.size() == 0 && q_done_cyc.size() == 0 && q_rej.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_drained"}, 32'(ok), 32'd1);
        q_byte.delete();
        q_done_cyc.delete();
        q_done_perr.delete();
        q_rej.delete();
    endtask

    task automatic basic_expect();
        push_byte(1'b1, 8'h0D);
        push_byte(1'b1, 8'h11);
        push_byte(1'b1, 8'h22);
        push_byte(1'b1, 8'h33);
        push_byte(1'b0, 8'h0D);
    endtask

    task automatic basic_load();
        load_byte(8'h11);
        load_byte(8'h22);
        load_byte(8'h33);
    endtask

    initial begin : stim
        logic [7:0] par;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_data_out", 32'(rif.data_out), 32'd0);
        check("rst_pkt_valid", 32'(rif.pkt_valid), 32'd0);
        check("rst_outputs", 32'({tx_active, buf_full, done, parity_err, reject}), 32'd0);
        check("rst_buf_count", 32'(buf_count), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 1. Basic packet
        basic_load();
        @(negedge clock);
        check("t1_buf_count", 32'(buf_count), 32'd3);
        basic_expect();
        fire_start(2'd1, 1'b0, 3 + 2 + ERR_WAIT, 1'b0);
        drain("t1");

        // 2. Back-pressure while 0x22 is presented
        basic_load();
        basic_expect();
        fire_start(2'd1, 1'b0, 3 + 2 + ERR_WAIT + 2, 1'b0);
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check("t2_hold_data", 32'(rif.data_out), 32'h22);
            check("t2_hold_valid", 32'(rif.pkt_valid), 32'd1);
            busy = (k < 2);
            if (k < 2) @(negedge clock);
        end
        busy = 1'b0;
        drain("t2");

        // 3. Router error during CHK, held, then cleared by a valid start
        basic_load();
        basic_expect();
        fire_start(2'd1, 1'b0, 3 + 2 + ERR_WAIT, 1'b1);
        repeat (7) @(negedge clock);
        err = 1'b1;
        @(negedge clock);
        err = 1'b0;
        drain("t3");
        repeat (3) @(negedge clock);
        check("t3_perr_held", 32'(parity_err), 32'd1);
        load_byte(8'h55);
        push_byte(1'b1, 8'h05);
        push_byte(1'b1, 8'h55);
        push_byte(1'b0, 8'h50);
        fire_start(2'd1, 1'b0, 1 + 2 + ERR_WAIT, 1'b0);
        @(negedge clock);
        check("t3_perr_cleared", 32'(parity_err), 32'd0);
        drain("t3b");

        // 4. Rejects
        fire_start(2'd0, 1'b1, -1, 1'b0);
        @(negedge clock);
        check("t4_empty_active", 32'(tx_active), 32'd0);
        load_byte(8'hA0);
        load_byte(8'hA1);
        fire_start(2'd3, 1'b1, -1, 1'b0);
        @(negedge clock);
        check("t4_addr3_count", 32'(buf_count), 32'd2);
        check("t4_addr3_active", 32'(tx_active), 32'd0);
        @(negedge clock);
        clr       = 1'b1;
        start     = 1'b1;
        dest_addr = 2'd1;
        @(posedge clock);
        #1;
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("t4_clr_count", 32'(buf_count), 32'd0);
        check("t4_clr_active", 32'(tx_active), 32'd0);
        drain("t4");

        // 5. Full buffer, 64th byte dropped, header 0xFE for dest 2
        for (int i = 0; i < 64; i++) load_byte(8'(i + 1));
        @(negedge clock);
        check("t5_count", 32'(buf_count), 32'd63);
        check("t5_full", 32'(buf_full), 32'd1);
        par = 8'hFE;
        push_byte(1'b1, 8'hFE);
        for (int i = 0; i < 63; i++) begin
            push_byte(1'b1, 8'(i + 1));
            par = par ^ 8'(i + 1);
        end
        push_byte(1'b0, par);
        fire_start(2'd2, 1'b0, 63 + 2 + ERR_WAIT, 1'b0);
        drain("t5");
        check("t5_full_after", 32'(buf_full), 32'd0);

        // 6. Reset after two payload bytes
        load_byte(8'hA1);
        load_byte(8'hA2);
        load_byte(8'hA3);
        push_byte(1'b1, 8'h0C);
        push_byte(1'b1, 8'hA1);
        push_byte(1'b1, 8'hA2);
        fire_start(2'd0, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rif.pkt_valid), 32'd0);
        check("t6_rst_data", 32'(rif.data_out), 32'd0);
        check("t6_rst_active", 32'(tx_active), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        check("t6_buf_count", 32'(buf_count), 32'd0);
        check("t6_active", 32'(tx_active), 32'd0);
        check("t6_bytes_seen", 32'(q_byte.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port. Software or a stimulus block loads the payload bytes into an internal buffer, then issues start with a destination address. The block frames and streams the packet to the router: header, payload, then parity. It honours the router's busy back-pressure, then collects the router's parity-error verdict. It sits directly upstream of the router top: data_out drives data_in, and pkt_valid drives pkt_valid.

Parameters:
MAX_LEN, 63, payload buffer depth in bytes; must be <= 63 (6-bit header length field)
ERR_WAIT, 4, cycles spent in CHK sampling the router err output after parity is accepted

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
wr_en  input  1  load wr_data into the payload buffer (IDLE only)
wr_data  input  8  payload byte
clr  input  1  discard buffered payload (IDLE only)
start  input  1  begin transmission of the buffered payload
dest_addr  input  2  destination port 0..2
busy  input  1  router busy; a byte transfers only on an edge where busy=0
err  input  1  router parity-error indication
data_out  output  8  byte to router data_in
pkt_valid  output  1  packet-valid to router
tx_active  output  1  high in any state other than IDLE
buf_count  output  6  bytes currently buffered
buf_full  output  1  buf_count == MAX_LEN
done  output  1  one-cycle pulse at end of CHK
parity_err  output  1  err was seen during CHK; updates with done, held until next accepted start
reject  output  1  one-cycle pulse when start is refused

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, buf_count 0, parity accumulator 0.
  - Reset mid-packet drops pkt_valid immediately; the partial packet is abandoned.
- States: IDLE, HDR, PLD, PAR, CHK. Only one clock domain.
- Transfer rule: in HDR, PLD or PAR, the presented byte is consumed on a rising edge with busy=0. With busy=1, data_out and pkt_valid hold unchanged.
- IDLE:
  - wr_en with buf_count<MAX_LEN writes buf[buf_count] and increments the count.
  - wr_en when full is ignored.
- IDLE priority: clr > start > wr_en.
  - clr: buf_count<=0; no reject pulse.
  - start with buf_count==0 or dest_addr==3: reject pulse, stay in IDLE.
  - Valid start: latch len=buf_count and addr, clear parity_err, go to HDR next edge. wr_en is ignored that cycle.
- HDR: data_out={len,addr}, pkt_valid=1. On transfer: parity<=header, index<=0, go to PLD.
- PLD: data_out=buf[index], pkt_valid=1. On transfer: parity^=byte, index++.
  - Transfer of byte len-1 goes to PAR.
- PAR: data_out=final parity, pkt_valid=0. On transfer go to CHK.
- CHK: data_out=0, pkt_valid=0. Counter runs ERR_WAIT cycles; any err=1 sets the sticky flag.
  - At expiry: done=1 for one cycle, parity_err<=flag, buf_count<=0, state IDLE.
- Inputs wr_en, clr and start are ignored outside IDLE; no reject pulse is raised for them.
- Minimum packet latency with busy=0: start edge, then header, then len payload edges, then parity edge, then ERR_WAIT cycles, then done.
  - Total: len+2+ERR_WAIT cycles after the start edge.
- Registered outputs only; no combinational path from busy to data_out.

Decomposition:
- Shared router package holds:
  - state encoding constants
  - header field positions: length [7:2], address [1:0]
  - the address-3 invalid constant
- Sub-module router_tx_buf holds the MAX_LEN x 8 buffer:
  - write port with count
  - asynchronous read by index
- The FSM, parity accumulator and CHK counter stay in router_pkt_tx.

Test Plan:
1. Basic packet: load 0x11,0x22,0x33; start dest_addr=1; busy=0.
   Required: data_out sequence 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0. done arrives 9 cycles after start, parity_err=0, buf_count=0.
2. Back-pressure: same packet with busy=1 for 2 cycles while 0x22 is presented.
   Required: 0x22 held 3 cycles, pkt_valid stays 1, parity still 0x0D, done delayed by 2.
3. Router error: basic packet with err=1 for one cycle in CHK.
   Required: parity_err=1 with done and held; cleared on the next valid start.
4. Rejects:
   - start with empty buffer: reject pulse, tx_active stays 0.
   - start with dest_addr=3 and 2 bytes loaded: reject pulse, buf_count stays 2.
   - clr together with start: buf_count=0, no reject.
5. Full buffer: 64 wr_en pulses.
   Required: buf_count=63, buf_full=1, 64th byte dropped. With dest_addr=2, header is 0xFE.
6. Reset mid-PLD (after 2 payload bytes): resetn low.
   Required: pkt_valid=0 and data_out=0 immediately. After release: IDLE, buf_count=0, done never pulses.
